// File: rtl/rf_mul_pkg.sv
// Shared constants and state encoding for the register-file multiply sequencer.
package rf_mul_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 3;
  localparam int MUL_CYCLES = DATA_W;
  localparam int CNT_W      = $clog2(MUL_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ_A   = 3'd1,
    ST_READ_B   = 3'd2,
    ST_MULT     = 3'd3,
    ST_WRITE_LO = 3'd4,
    ST_WRITE_HI = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/rf_mul_sequencer_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier: one partial product per step, fixed W steps.
module shift_add_core #(
  parameter int W = rf_mul_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cap_a,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_operand,
  output logic [W-1:0] o_product_hi,
  output logic [W-1:0] o_product_lo_nxt,
  output logic         o_last
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_count;
  logic [W-1:0]  w_addend;
  logic [W:0]    w_sum;

  // The multiplier register doubles as the low half of the product as it shifts out.
  assign w_addend         = r_mplier[0] ? r_mcand : '0;
  assign w_sum            = {1'b0, r_acc} + {1'b0, w_addend};
  assign o_product_hi     = r_acc;
  assign o_product_lo_nxt = {w_sum[0], r_mplier[W-1:1]};
  assign o_last           = (r_count == CW'(W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_cap_a) begin
      r_mcand <= i_operand;
    end else if (i_load) begin
      r_mplier <= i_operand;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= w_sum[W:1];
      r_mplier <= {w_sum[0], r_mplier[W-1:1]};
      r_count  <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/rf_mul_sequencer.sv
// Reads two registers, multiplies them, and writes the 64-bit product to d_addr/d_addr+1.
module rf_mul_sequencer #(
  parameter int DATA_W = rf_mul_pkg::DATA_W,
  parameter int ADDR_W = rf_mul_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rData,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  output logic              we,
  output logic              busy,
  output logic              done
);
  import rf_mul_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_b_addr;
  logic [ADDR_W-1:0] r_d_addr;
  logic [DATA_W-1:0] w_product_hi;
  logic [DATA_W-1:0] w_product_lo_nxt;
  logic              w_last;

  shift_add_core #(.W(DATA_W)) u_core (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_cap_a          (r_state == ST_READ_A),
    .i_load           (r_state == ST_READ_B),
    .i_step           (r_state == ST_MULT),
    .i_operand        (rData),
    .o_product_hi     (w_product_hi),
    .o_product_lo_nxt (w_product_lo_nxt),
    .o_last           (w_last)
  );

  // Command FSM; the low word is taken from the final step's result so it is ready in WRITE_LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_b_addr <= '0;
      r_d_addr <= '0;
      rAddr    <= '0;
      wAddr    <= '0;
      wData    <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          we   <= 1'b0;
          done <= 1'b0;
          if (start) begin
            r_b_addr <= b_addr;
            r_d_addr <= d_addr;
            rAddr    <= a_addr;
            busy     <= 1'b1;
            r_state  <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          rAddr   <= r_b_addr;
          r_state <= ST_READ_B;
        end
        ST_READ_B: begin
          r_state <= ST_MULT;
        end
        ST_MULT: begin
          if (w_last) begin
            wAddr   <= r_d_addr;
            wData   <= w_product_lo_nxt;
            we      <= 1'b1;
            r_state <= ST_WRITE_LO;
          end
        end
        ST_WRITE_LO: begin
          wAddr   <= r_d_addr + ADDR_W'(1);
          wData   <= w_product_hi;
          we      <= 1'b1;
          r_state <= ST_WRITE_HI;
        end
        ST_WRITE_HI: begin
          we      <= 1'b0;
          done    <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          we      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_mul_sequencer.sv
// Directed bench: behavioural 8x32 register file around rf_mul_sequencer, hand-computed products.
module tb_rf_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  a_addr = 3'd0, b_addr = 3'd0, d_addr = 3'd0;
  logic [2:0]  rAddr, wAddr;
  logic [31:0] rData, wData;
  logic        we, busy, done;

  logic [31:0] rf [8];
  logic        tb_we = 1'b0;
  logic [2:0]  tb_waddr = 3'd0;
  logic [31:0] tb_wdata = 32'd0;

  int vecs = 0;
  int errs = 0;

  int         m_done_cyc, m_done_cnt, m_we_cnt;
  logic [2:0] m_wa_lo, m_wa_hi;
  logic       m_busy_ok;

  rf_mul_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_addr(a_addr), .b_addr(b_addr), .d_addr(d_addr),
    .rAddr(rAddr), .rData(rData), .wAddr(wAddr), .wData(wData),
    .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rData = rf[rAddr];

  always @(posedge clk) begin
    if (we) rf[wAddr] <= wData;
    else if (tb_we) rf[tb_waddr] <= tb_wdata;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task poke(input logic [2:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick;
    tb_we = 1'b0;
  endtask

  // Issue one command and observe cycles 1..37 after the accepting edge; ends in cycle 38.
  task run_cmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
               input int g1, input int g2);
    start = 1'b1; a_addr = a; b_addr = b; d_addr = d;
    tick;
    start = 1'b0; a_addr = ~a; b_addr = ~b; d_addr = ~d;
    m_done_cyc = 0; m_done_cnt = 0; m_we_cnt = 0;
    m_wa_lo = 3'd0; m_wa_hi = 3'd0; m_busy_ok = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      start = (c == g1) || (c == g2);
      if (done === 1'b1) begin
        m_done_cnt++;
        if (m_done_cyc == 0) m_done_cyc = c;
      end
      if (we === 1'b1) begin
        m_we_cnt++;
        if (c == 35) m_wa_lo = wAddr;
        if (c == 36) m_wa_hi = wAddr;
      end
      if (busy !== 1'b1) m_busy_ok = 1'b0;
      tick;
    end
    start = 1'b0;
  endtask

  task test_reset;
    #3;
    vecs++;
    if ({we, busy, done, rAddr, wAddr, wData} !== 41'd0) begin
      errs++;
      $display("FAIL reset_state: got we=%b busy=%b done=%b rAddr=%0d wAddr=%0d wData=%h, want all 0",
               we, busy, done, rAddr, wAddr, wData);
    end
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) poke(i[2:0], 32'd0);
    vecs++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_quiet: got we=%b busy=%b, want 0 0", we, busy);
    end
  endtask

  task test_basic;
    poke(3'd1, 32'd3); poke(3'd2, 32'd5); poke(3'd5, 32'h11111111);
    run_cmd(3'd1, 3'd2, 3'd4, 0, 0);
    vecs++;
    if (m_done_cyc != 37 || m_done_cnt != 1) begin
      errs++;
      $display("FAIL basic_latency: got done at %0d count %0d, want 37 count 1", m_done_cyc, m_done_cnt);
    end
    vecs++;
    if (m_we_cnt != 2 || m_wa_lo !== 3'd4 || m_wa_hi !== 3'd5) begin
      errs++;
      $display("FAIL basic_writes: got we_cnt=%0d wAddr %0d,%0d, want 2 and 4,5", m_we_cnt, m_wa_lo, m_wa_hi);
    end
    vecs++;
    if (!m_busy_ok || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL basic_busy: got busy_ok=%b busy=%b done=%b at cycle 38, want 1 0 0", m_busy_ok, busy, done);
    end
    vecs++;
    if (rf[4] !== 32'd15 || rf[5] !== 32'd0) begin
      errs++;
      $display("FAIL basic_result: got r4=%h r5=%h, want 0000000f 00000000", rf[4], rf[5]);
    end
  endtask

  task test_max_wrap;
    poke(3'd0, 32'hFFFFFFFF); poke(3'd1, 32'hFFFFFFFF); poke(3'd7, 32'h0);
    run_cmd(3'd0, 3'd1, 3'd7, 0, 0);
    vecs++;
    if (m_wa_lo !== 3'd7 || m_wa_hi !== 3'd0) begin
      errs++;
      $display("FAIL wrap_addr: got wAddr %0d,%0d, want 7,0", m_wa_lo, m_wa_hi);
    end
    vecs++;
    if (rf[7] !== 32'h00000001 || rf[0] !== 32'hFFFFFFFE) begin
      errs++;
      $display("FAIL max_result: got r7=%h r0=%h, want 00000001 fffffffe", rf[7], rf[0]);
    end
  endtask

  task test_square;
    poke(3'd3, 32'h12345678); poke(3'd4, 32'hCAFEF00D);
    run_cmd(3'd3, 3'd3, 3'd3, 0, 0);
    vecs++;
    if (rf[3] !== 32'h1DF4D840 || rf[4] !== 32'h014B66DC) begin
      errs++;
      $display("FAIL square_result: got r3=%h r4=%h, want 1df4d840 014b66dc", rf[3], rf[4]);
    end
  endtask

  task test_back_to_back;
    poke(3'd1, 32'h00010000); poke(3'd2, 32'h00010000);
    run_cmd(3'd1, 3'd2, 3'd6, 5, 36);
    vecs++;
    if (m_done_cyc != 37 || m_done_cnt != 1 || m_we_cnt != 2) begin
      errs++;
      $display("FAIL ignore_start: got done at %0d count %0d we_cnt %0d, want 37 1 2",
               m_done_cyc, m_done_cnt, m_we_cnt);
    end
    vecs++;
    if (rf[6] !== 32'h0 || rf[7] !== 32'h1) begin
      errs++;
      $display("FAIL ignore_result: got r6=%h r7=%h, want 00000000 00000001", rf[6], rf[7]);
    end
    run_cmd(3'd7, 3'd2, 3'd0, 0, 0);
    vecs++;
    if (m_done_cyc != 37 || m_we_cnt != 2) begin
      errs++;
      $display("FAIL b2b_accept: got done at %0d we_cnt %0d, want 37 2", m_done_cyc, m_we_cnt);
    end
    vecs++;
    if (rf[0] !== 32'h00010000 || rf[1] !== 32'h0) begin
      errs++;
      $display("FAIL b2b_result: got r0=%h r1=%h, want 00010000 00000000", rf[0], rf[1]);
    end
  endtask

  task test_reset_mid;
    poke(3'd1, 32'd7); poke(3'd2, 32'd9);
    poke(3'd4, 32'hAAAA0000); poke(3'd5, 32'h00005555);
    start = 1'b1; a_addr = 3'd1; b_addr = 3'd2; d_addr = 3'd4;
    tick;
    start = 1'b0;
    repeat (19) tick;
    #2;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({we, busy, done, rAddr, wAddr, wData} !== 41'd0) begin
      errs++;
      $display("FAIL reset_mid: got we=%b busy=%b done=%b rAddr=%0d wAddr=%0d wData=%h, want all 0",
               we, busy, done, rAddr, wAddr, wData);
    end
    tick; tick;
    vecs++;
    if (rf[4] !== 32'hAAAA0000 || rf[5] !== 32'h00005555) begin
      errs++;
      $display("FAIL reset_nowrite: got r4=%h r5=%h, want aaaa0000 00005555", rf[4], rf[5]);
    end
    #2;
    reset_n = 1'b1;
    tick;
    run_cmd(3'd1, 3'd2, 3'd4, 0, 0);
    vecs++;
    if (m_done_cyc != 37 || rf[4] !== 32'd63 || rf[5] !== 32'd0) begin
      errs++;
      $display("FAIL reset_recover: got done at %0d r4=%h r5=%h, want 37 0000003f 00000000",
               m_done_cyc, rf[4], rf[5]);
    end
  endtask

  task test_zero;
    poke(3'd6, 32'd0); poke(3'd2, 32'hDEADBEEF); poke(3'd1, 32'h76543210);
    run_cmd(3'd6, 3'd2, 3'd1, 0, 0);
    vecs++;
    if (m_done_cyc != 37) begin
      errs++;
      $display("FAIL zero_latency: got done at %0d, want 37", m_done_cyc);
    end
    vecs++;
    if (rf[1] !== 32'd0 || rf[2] !== 32'd0) begin
      errs++;
      $display("FAIL zero_result: got r1=%h r2=%h, want 00000000 00000000", rf[1], rf[2]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_wrap;
    test_square;
    test_back_to_back;
    test_reset_mid;
    test_zero;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
